// File: rtl/wb_queue.sv
// wb_queue: in-order write-back queue in front of the register file's single
// write port. Load and ALU results are enqueued (load first), PC updates to r7
// take the port directly and stall the queue, and per-register busy flags
// expose pending writes for RAW hazard detection.
// Optional feature: define WB_FORWARD_EN to add the fwd_addr/fwd_hit/fwd_data
// lookup of the youngest queued value for a register.
module wb_queue #(
    parameter int DW    = 16,
    parameter int AW    = 3,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [AW-1:0]       ld_addr,
    input  logic [DW-1:0]       ld_data,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [AW-1:0]       alu_addr,
    input  logic [DW-1:0]       alu_data,
    input  logic                pc_we,
    input  logic [DW-1:0]       pc_next,
    output logic                regen,
    output logic [AW-1:0]       inaddr,
    output logic [DW-1:0]       in,
    output logic [(2**AW)-1:0]  busy,
`ifdef WB_FORWARD_EN
    input  logic [AW-1:0]       fwd_addr,
    output logic                fwd_hit,
    output logic [DW-1:0]       fwd_data,
`endif
    output logic                full,
    output logic                empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NR = 2**AW;

    // Queue control state (reset) and payload storage (not reset)
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];

    logic             ld_take;
    logic             alu_take;
    logic             push;
    logic             pop;
    logic [AW-1:0]    push_addr;
    logic [DW-1:0]    push_data;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Ready never looks at a same-cycle pop, so a full queue always stalls.
    assign ld_ready  = !rst && !full;
    assign alu_ready = !rst && !full && !ld_valid;

    assign ld_take   = ld_valid && ld_ready;
    assign alu_take  = alu_valid && alu_ready;
    assign push      = ld_take || alu_take;
    assign push_addr = ld_take ? ld_addr : alu_addr;
    assign push_data = ld_take ? ld_data : alu_data;

    // The head only leaves when the port is not claimed by a PC update.
    assign pop = !rst && !pc_we && !empty;

    // Write-port mux: PC update first, then the queue head, otherwise idle zeros
    always_comb begin
        regen  = 1'b0;
        inaddr = '0;
        in     = '0;
        if (!rst) begin
            if (pc_we) begin
                regen  = 1'b1;
                inaddr = AW'(7);
                in     = pc_next;
            end else if (!empty) begin
                regen  = 1'b1;
                inaddr = addr_q[head_q];
                in     = data_q[head_q];
            end
        end
    end

    // Next-state for pointers, occupancy and per-entry valid bits
    always_comb begin
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        vld_d   = vld_q;
        if (pop) begin
            vld_d[head_q] = 1'b0;
        end
        // push never targets the head slot while it is popping: push needs
        // !full and pop needs !empty, so tail != head whenever both occur.
        if (push) begin
            vld_d[tail_q] = 1'b1;
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    // Payload write at the tail; push is already suppressed during reset
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= push_addr;
            data_q[tail_q] <= push_data;
        end
    end

    // Occupancy must never pass DEPTH
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_no_overflow: assert (!(push && !pop && full));
        end
    end

    // Pending-write flags: decoded destination of every valid entry
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                busy[addr_q[i]] = 1'b1;
            end
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_hit = busy[fwd_addr];

    // Scan oldest to youngest so the last match (youngest) wins
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (vld_q[idx] && (addr_q[idx] == fwd_addr)) begin
                fwd_data = data_q[idx];
            end
        end
    end
`endif

    // NR is the size of the busy vector; tie it to AW for readers.
    if (NR != (1 << AW)) begin : g_bad_nr
        $error("busy width mismatch");
    end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: reset, idle, arbitration, PC priority,
// backpressure and ordering across a pointer wrap.
module tb_wb_queue;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid, ld_ready, alu_valid, alu_ready, pc_we;
    logic [AW-1:0] ld_addr, alu_addr, inaddr;
    logic [DW-1:0] ld_data, alu_data, pc_next, in;
    logic          regen, full, empty;
    logic [7:0]    busy;
`ifdef WB_FORWARD_EN
    logic [AW-1:0] fwd_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Writes the register file will take on the following posedge
    logic [AW+DW-1:0] wlog[$];

    always #5 clk = ~clk;

    wb_queue #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .pc_we(pc_we), .pc_next(pc_next),
        .regen(regen), .inaddr(inaddr), .in(in), .busy(busy),
`ifdef WB_FORWARD_EN
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
        .full(full), .empty(empty)
    );

    always @(negedge clk) begin
        if (regen === 1'b1) wlog.push_back({inaddr, in});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_we = 1'b1; pc_next = 16'h0055;
        ld_valid = 1'b1; ld_addr = 3'd1; ld_data = 16'h1111;
        alu_valid = 1'b1; alu_addr = 3'd2; alu_data = 16'h2222;
        settle();
        n_chk++; if (regen !== 1'b0) begin n_fail++; $display("FAIL rst_regen: got %b want 0", regen); end
        n_chk++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ld_ready: got %b want 0", ld_ready); end
        n_chk++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_alu_ready: got %b want 0", alu_ready); end
        cyc();
        pc_we = 1'b0; ld_valid = 1'b0; alu_valid = 1'b0;
        settle();
        n_chk++; if ({empty, full, busy} !== {1'b1, 1'b0, 8'h00})
            begin n_fail++; $display("FAIL rst_state: got empty=%b full=%b busy=%h want 1 0 00", empty, full, busy); end
        cyc();
        rst = 1'b0;
        settle();
        n_chk++; if ({regen, empty} !== 2'b01) begin n_fail++; $display("FAIL rst_release: got regen=%b empty=%b want 0 1", regen, empty); end
    endtask

    task automatic test_empty_idle();
        cyc();
        for (int k = 0; k < 3; k++) begin
            settle();
            n_chk++; if ({regen, empty, inaddr, in} !== {1'b0, 1'b1, 3'd0, 16'h0000})
                begin n_fail++; $display("FAIL idle_%0d: got regen=%b empty=%b inaddr=%0d in=%h want 0 1 0 0000", k, regen, empty, inaddr, in); end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        int stale;
        cyc();
        wlog.delete();
        pc_we = 1'b1; pc_next = 16'h0100;
        alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 16'h0011;
        settle();
        n_chk++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL mid_alu_ready: got %b want 1", alu_ready); end
        cyc(); alu_addr = 3'd2; alu_data = 16'h0022;
        cyc(); alu_addr = 3'd3; alu_data = 16'h0033;
        cyc(); alu_valid = 1'b0;
        settle();
        n_chk++; if ({busy, empty} !== {8'h0E, 1'b0}) begin n_fail++; $display("FAIL mid_queued: got busy=%h empty=%b want 0e 0", busy, empty); end
        cyc(); rst = 1'b1;
        settle();
        n_chk++; if (regen !== 1'b0) begin n_fail++; $display("FAIL mid_rst_regen: got %b want 0", regen); end
        cyc(); rst = 1'b0; pc_we = 1'b0;
        settle();
        n_chk++; if ({empty, busy, regen} !== {1'b1, 8'h00, 1'b0})
            begin n_fail++; $display("FAIL mid_after_rst: got empty=%b busy=%h regen=%b want 1 00 0", empty, busy, regen); end
        cyc();
        settle();
        n_chk++; if (regen !== 1'b0) begin n_fail++; $display("FAIL mid_no_drain: got regen=%b want 0", regen); end
        stale = 0;
        foreach (wlog[j]) if (wlog[j][AW+DW-1:DW] inside {3'd1, 3'd2, 3'd3}) stale++;
        n_chk++; if (stale !== 0) begin n_fail++; $display("FAIL mid_stale_writes: got %0d want 0", stale); end
    endtask

    task automatic test_arbitration();
        cyc();
        wlog.delete();
        ld_valid = 1'b1; ld_addr = 3'd4; ld_data = 16'hBEEF;
        alu_valid = 1'b1; alu_addr = 3'd5; alu_data = 16'h1234;
        settle();
        n_chk++; if ({ld_ready, alu_ready, regen} !== 3'b100)
            begin n_fail++; $display("FAIL arb_c1: got ld_ready=%b alu_ready=%b regen=%b want 1 0 0", ld_ready, alu_ready, regen); end
        cyc(); ld_valid = 1'b0;
        settle();
        n_chk++; if ({alu_ready, regen, inaddr, in} !== {1'b1, 1'b1, 3'd4, 16'hBEEF})
            begin n_fail++; $display("FAIL arb_c2: got alu_ready=%b regen=%b inaddr=%0d in=%h want 1 1 4 beef", alu_ready, regen, inaddr, in); end
        cyc(); alu_valid = 1'b0;
        settle();
        n_chk++; if ({regen, inaddr, in, busy} !== {1'b1, 3'd5, 16'h1234, 8'h20})
            begin n_fail++; $display("FAIL arb_c3: got regen=%b inaddr=%0d in=%h busy=%h want 1 5 1234 20", regen, inaddr, in, busy); end
        cyc();
        settle();
        n_chk++; if ({empty, regen, busy} !== {1'b1, 1'b0, 8'h00})
            begin n_fail++; $display("FAIL arb_drained: got empty=%b regen=%b busy=%h want 1 0 00", empty, regen, busy); end
        n_chk++; if (wlog.size() !== 2) begin n_fail++; $display("FAIL arb_write_count: got %0d want 2", wlog.size()); end
        else if (wlog[0] !== {3'd4, 16'hBEEF} || wlog[1] !== {3'd5, 16'h1234})
            begin n_fail++; $display("FAIL arb_write_order: got %h %h want 4beef 51234", wlog[0], wlog[1]); end
    endtask

    task automatic test_pc_priority();
        cyc();
        alu_valid = 1'b1; alu_addr = 3'd2; alu_data = 16'h00AA;
        cyc();
        alu_valid = 1'b0; pc_we = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pc_next = 16'h0010 + 16'(k);
            settle();
            n_chk++; if ({regen, inaddr, in, busy[2]} !== {1'b1, 3'd7, 16'h0010 + 16'(k), 1'b1})
                begin n_fail++; $display("FAIL pc_cycle_%0d: got regen=%b inaddr=%0d in=%h busy2=%b want 1 7 %h 1", k, regen, inaddr, in, busy[2], 16'h0010 + 16'(k)); end
            cyc();
        end
        pc_we = 1'b0;
        settle();
        n_chk++; if ({regen, inaddr, in, busy[2]} !== {1'b1, 3'd2, 16'h00AA, 1'b1})
            begin n_fail++; $display("FAIL pc_r2_write: got regen=%b inaddr=%0d in=%h busy2=%b want 1 2 00aa 1", regen, inaddr, in, busy[2]); end
        cyc();
        settle();
        n_chk++; if ({busy[2], empty} !== 2'b01) begin n_fail++; $display("FAIL pc_r2_cleared: got busy2=%b empty=%b want 0 1", busy[2], empty); end
    endtask

    task automatic test_full();
        cyc();
        pc_we = 1'b1; pc_next = 16'h0020; alu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_addr = 3'(i + 1); alu_data = 16'h1000 + 16'(i);
            settle();
            n_chk++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill_%0d: got alu_ready=%b want 1", i, alu_ready); end
            cyc();
        end
        alu_addr = 3'd6; alu_data = 16'h0505;
        settle();
        n_chk++; if ({full, alu_ready, ld_ready, busy} !== {1'b1, 1'b0, 1'b0, 8'h1E})
            begin n_fail++; $display("FAIL full_state: got full=%b alu_ready=%b ld_ready=%b busy=%h want 1 0 0 1e", full, alu_ready, ld_ready, busy); end
        cyc();
        settle();
        n_chk++; if ({full, alu_ready} !== 2'b10) begin n_fail++; $display("FAIL full_held: got full=%b alu_ready=%b want 1 0", full, alu_ready); end
        cyc();
        wlog.delete(); pc_we = 1'b0;
        settle();
        n_chk++; if ({alu_ready, inaddr} !== {1'b0, 3'd1}) begin n_fail++; $display("FAIL full_no_passthru: got alu_ready=%b inaddr=%0d want 0 1", alu_ready, inaddr); end
        cyc();
        settle();
        n_chk++; if ({full, alu_ready} !== 2'b01) begin n_fail++; $display("FAIL full_after_pop: got full=%b alu_ready=%b want 0 1", full, alu_ready); end
        cyc();
        alu_valid = 1'b0;
        repeat (4) cyc();
        settle();
        n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drain_empty: got %b want 1", empty); end
        n_chk++; if (wlog.size() !== 5) begin n_fail++; $display("FAIL full_write_count: got %0d want 5", wlog.size()); end
        else if (wlog[0] !== {3'd1, 16'h1000} || wlog[1] !== {3'd2, 16'h1001} || wlog[2] !== {3'd3, 16'h1002} ||
                 wlog[3] !== {3'd4, 16'h1003} || wlog[4] !== {3'd6, 16'h0505})
            begin n_fail++; $display("FAIL full_write_order: got %h %h %h %h %h want 11000 21001 31002 41003 60505", wlog[0], wlog[1], wlog[2], wlog[3], wlog[4]); end
    endtask

    task automatic test_wrap();
        cyc();
        alu_valid = 1'b1; alu_addr = 3'd6; alu_data = 16'h0600;
        cyc(); alu_data = 16'h0601;
        cyc(); alu_data = 16'h0602;
        cyc(); alu_valid = 1'b0;
        cyc();
        pc_we = 1'b1; pc_next = 16'h0030;
        alu_valid = 1'b1; alu_addr = 3'd3;
        for (int k = 1; k <= 3; k++) begin
            alu_data = 16'(k);
            cyc();
        end
        alu_valid = 1'b0;
        settle();
        n_chk++; if ({busy, empty} !== {8'h08, 1'b0}) begin n_fail++; $display("FAIL wrap_queued: got busy=%h empty=%b want 08 0", busy, empty); end
`ifdef WB_FORWARD_EN
        fwd_addr = 3'd3;
        #1;
        n_chk++; if ({fwd_hit, fwd_data} !== {1'b1, 16'h0003}) begin n_fail++; $display("FAIL fwd_r3: got hit=%b data=%h want 1 0003", fwd_hit, fwd_data); end
        fwd_addr = 3'd5;
        #1;
        n_chk++; if ({fwd_hit, fwd_data} !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL fwd_r5: got hit=%b data=%h want 0 0000", fwd_hit, fwd_data); end
`endif
        cyc();
        wlog.delete(); pc_we = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            settle();
            n_chk++; if ({busy[3], inaddr, in} !== {1'b1, 3'd3, 16'(k)})
                begin n_fail++; $display("FAIL wrap_write_%0d: got busy3=%b inaddr=%0d in=%h want 1 3 %h", k, busy[3], inaddr, in, 16'(k)); end
            cyc();
        end
        settle();
        n_chk++; if ({busy[3], empty} !== 2'b01) begin n_fail++; $display("FAIL wrap_done: got busy3=%b empty=%b want 0 1", busy[3], empty); end
        n_chk++; if (wlog.size() !== 3) begin n_fail++; $display("FAIL wrap_write_count: got %0d want 3", wlog.size()); end
        else if (wlog[2] !== {3'd3, 16'h0003}) begin n_fail++; $display("FAIL wrap_final_r3: got %h want 30003", wlog[2]); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded 100000 time units, required completion");
        $fatal(1);
    end

    initial begin
        ld_valid = 1'b0; alu_valid = 1'b0; pc_we = 1'b0; rst = 1'b1;
        ld_addr = '0; ld_data = '0; alu_addr = '0; alu_data = '0; pc_next = '0;
`ifdef WB_FORWARD_EN
        fwd_addr = '0;
`endif
        test_reset();
        test_empty_idle();
        test_reset_mid();
        test_arbitration();
        test_pc_priority();
        test_full();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-side companion to the 8x16 register file: collects register-write requests from the ALU and load paths and serialises them onto the register file's single write port (regen/inaddr/in).
- PC updates to r7 share that port. They always win, and queued writes wait in an in-order FIFO.
- Exports per-register pending-write flags so the issue logic can detect RAW hazards.

Parameters:
- DW, 16, data width (matches register file).
- AW, 3, register address width (8 registers; r7 = PC).
- DEPTH, 4, queue entries (power of 2, >= 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset, sampled on posedge clk.
- ld_valid  in  1  load result valid.
- ld_ready  out  1  queue accepts load result this cycle.
- ld_addr  in  AW  load destination register.
- ld_data  in  DW  load result.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  queue accepts ALU result this cycle.
- alu_addr  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- pc_we  in  1  PC update request this cycle.
- pc_next  in  DW  new PC value.
- regen  out  1  register file write enable.
- inaddr  out  AW  register file write address.
- in  out  DW  register file write data.
- busy  out  2**AW  busy[r]=1 iff a queued, not yet written entry targets r.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset: on a posedge with rst=1:
  - head, tail and count are cleared.
  - Entry valid bits are cleared, so busy=0, empty=1, full=0.
  - Anything in flight is discarded.
- While rst=1, regen=0, ld_ready=0 and alu_ready=0 combinationally, regardless of pc_we.
- Enqueue arbitration: at most one enqueue per cycle. Load has priority.
  - ld_ready = !rst && !full.
  - alu_ready = !rst && !full && !ld_valid.
  - A transfer occurs on a posedge where valid && ready.
  - The entry {addr,data} is written at tail, and tail advances modulo DEPTH.
  - No pass-through when full: a pop in the same cycle does not raise ready.
- Write-port mux (combinational, outside reset):
  - If pc_we: regen=1, inaddr=7, in=pc_next. No pop.
  - Else if !empty: regen=1, inaddr/in = head entry. Head pops on the same posedge, advancing modulo DEPTH.
  - Else regen=0; inaddr and in are driven 0.
- Latency:
  - Request accepted at edge N reaches the register file at edge N+1 at the earliest.
  - Each pc_we cycle and each older queued entry adds one cycle.
- Count: +1 on enqueue, -1 on pop; a simultaneous enqueue and pop leaves it unchanged.
- Ordering: strict FIFO. Two writes to the same register land in acceptance order, so the last accepted value wins.
- Queued writes to r7 (jump targets) are legal. They are ordered only against other queued entries, not against pc_we.
  - Issue logic must hold pc_we while busy[7]=1.
  - wb_queue does not check this.
- busy: OR over valid entries of the decoded address. It updates on the posedge of enqueue or pop.
  - An entry popped at edge N is not busy after N.
- Wrap-around: pointers are AW-independent log2(DEPTH) bits and wrap naturally. Full is derived from count, never from pointer equality alone.
- Overflow and underflow cannot occur by construction. An assertion fires if count would exceed DEPTH.

Optional Feature:
- Macro: WB_FORWARD_EN.
- When defined, adds these ports:
  - fwd_addr  in  AW.
  - fwd_hit  out  1.
  - fwd_data  out  DW.
- Forwarding lookup:
  - fwd_hit = busy[fwd_addr].
  - fwd_data = data of the youngest queued entry whose addr == fwd_addr; 0 if no hit.
  - Purely combinational from queue state, and reflects the state before the current edge.
- When undefined, these ports do not exist and no compare logic is built.

Test Plan:
- Reset mid-operation: queue 3 ALU writes (r1=0x0011, r2=0x0022, r3=0x0033) with pc_we=1 held so nothing pops, then rst for 1 cycle -> empty=1, busy=0x00, regen=0; the register file is never written with those values.
- Arbitration: ld_valid and alu_valid both high, ld r4=0xBEEF, alu r5=0x1234 -> cycle 1: ld_ready=1, alu_ready=0, ld accepted. Cycle 2: alu accepted. Writes r4 then r5 on consecutive edges with regen=1.
- PC priority: queue r2=0x00AA, assert pc_we for 3 cycles with pc_next=0x0010,0x0011,0x0012 -> inaddr=7 for those 3 cycles, busy[2]=1 throughout. r2 is written on the 4th cycle; busy[2] clears after that edge.
- Full/backpressure: pc_we held, enqueue 4 ALU writes -> full=1, alu_ready=0, and a 5th request is held. Drop pc_we -> 4 writes drain in order, full deasserts after the first pop, and the 5th is accepted.
- Same-register ordering and wrap: enqueue r3=0x0001, r3=0x0002, r3=0x0003 across a pointer wrap (prior 3 push/pop pairs) -> final r3=0x0003, busy[3] drops only after the last write. With WB_FORWARD_EN, fwd_addr=3 gives fwd_data=0x0003 while queued.
- Empty idle: no requests, pc_we=0 -> regen=0 every cycle, empty=1, inaddr=0, in=0.
